// File: rtl/mem_access_unit_pkg.sv
// Purpose: shared op encodings, FSM states and lane helpers for the MEM-stage access unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    // Load op encodings on MEM_READ (6 and 7 decode as no-op)
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    // Store op encodings on MEM_WRITE (4..7 decode as no-op)
    localparam logic [2:0] SO_NONE = 3'd0;
    localparam logic [2:0] SO_SB   = 3'd1;
    localparam logic [2:0] SO_SH   = 3'd2;
    localparam logic [2:0] SO_SW   = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } store_lanes_t;

    function automatic logic is_store(input logic [2:0] op);
        is_store = (op == SO_SB) || (op == SO_SH) || (op == SO_SW);
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        is_load = (op == LD_LB) || (op == LD_LH) || (op == LD_LW) ||
                  (op == LD_LBU) || (op == LD_LHU);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0
    function automatic logic op_misaligned(input logic [2:0] op, input logic store,
                                           input logic [1:0] a);
        logic half;
        logic word;
        half = store ? (op == SO_SH) : ((op == LD_LH) || (op == LD_LHU));
        word = store ? (op == SO_SW) : (op == LD_LW);
        op_misaligned = (half && a[0]) || (word && (a != 2'b00));
    endfunction

    // Replicate the store operand across all lanes; byte enables pick the live ones
    function automatic store_lanes_t store_align(input logic [2:0] op, input logic [31:0] d,
                                                 input logic [1:0] a);
        store_lanes_t s;
        s.data = '0;
        s.be   = '0;
        case (op)
            SO_SB: begin
                s.data = {4{d[7:0]}};
                s.be   = 4'b0001 << a;
            end
            SO_SH: begin
                s.data = {2{d[15:0]}};
                s.be   = 4'b0011 << {a[1], 1'b0};
            end
            SO_SW: begin
                s.data = d;
                s.be   = 4'b1111;
            end
            default: ;
        endcase
        store_align = s;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_data_align.sv
// Purpose: pick the addressed byte/half lane out of a raw memory word and extend it.
// Latency: combinational.
// Backpressure: none.
module mem_access_unit_load_data_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by sign/zero extension per load op
    always_comb begin
        byte_lane = raw[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? raw[31:16] : raw[15:0];
        data      = '0;
        case (op)
            LD_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            LD_LH:   data = {{16{half_lane[15]}}, half_lane};
            LD_LW:   data = raw;
            LD_LBU:  data = {24'd0, byte_lane};
            LD_LHU:  data = {16'd0, half_lane};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage controller: decodes load/store, aligns lanes, runs req/ack with data memory.
// Latency: 3 cycles minimum per access (issue, ACCESS until ACK or timeout, DONE).
// Backpressure: BUSY_WAIT stalls the pipeline from issue through the last ACCESS cycle.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [2:0]            MEM_READ,
    input  logic [2:0]            MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0] ALU_RESULT,
    input  logic [31:0]           OUT2,
    output logic                  BUSY_WAIT,
    output logic [31:0]           READ_DATA,
    output logic                  MISALIGNED,
    output logic                  BUS_ERR,
    output logic                  DMEM_READ,
    output logic                  DMEM_WRITE,
    output logic [ADDR_WIDTH-3:0] DMEM_ADDRESS,
    output logic [31:0]           DMEM_WRITEDATA,
    output logic [3:0]            DMEM_BYTEEN,
    input  logic [31:0]           DMEM_READDATA,
    input  logic                  DMEM_ACK
);

    localparam int             CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT_CYCLES);
    localparam logic           TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W:0]          cnt_inc;
    logic                    wr_op;
    logic                    rd_op;
    logic                    misaligned_op;
    logic                    op_issue;
    logic                    timeout_hit;
    logic [1:0]              addr_lo;
    store_lanes_t            st_lanes;
    logic [31:0]             load_ext;

    logic                    dmem_read_q;
    logic                    dmem_write_q;
    logic [ADDR_WIDTH-3:0]   dmem_addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;
    logic [31:0]             read_data_q;
    logic [1:0]              lane_q;
    logic [2:0]              ld_op_q;
    logic                    bus_err_q;

    // A valid store takes priority; a load present alongside it is dropped
    assign addr_lo       = ALU_RESULT[1:0];
    assign wr_op         = is_store(MEM_WRITE);
    assign rd_op         = !wr_op && is_load(MEM_READ);
    assign misaligned_op = wr_op ? op_misaligned(MEM_WRITE, 1'b1, addr_lo)
                                 : (rd_op && op_misaligned(MEM_READ, 1'b0, addr_lo));
    assign op_issue      = (wr_op || rd_op) && !misaligned_op;
    assign st_lanes      = store_align(MEM_WRITE, OUT2, addr_lo);

    // cnt_inc is the number of ACCESS cycles completed at this edge
    assign cnt_inc     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign timeout_hit = TIMEOUT_EN && (state_q == S_ACCESS) && !DMEM_ACK &&
                         (cnt_inc == TIMEOUT_VAL);

    mem_access_unit_load_data_align u_load_align (
        .raw    (DMEM_READDATA),
        .offset (lane_q),
        .op     (ld_op_q),
        .data   (load_ext)
    );

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: DONE always falls back to IDLE so the same op is never re-issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (op_issue) state_d = S_ACCESS;
            S_ACCESS: if (DMEM_ACK || timeout_hit) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: stall asserted combinationally on issue, released in DONE, forced low in reset
    always_comb begin
        BUSY_WAIT  = 1'b0;
        MISALIGNED = 1'b0;
        if (!RESET) begin
            BUSY_WAIT  = ((state_q == S_IDLE) && op_issue) || (state_q == S_ACCESS);
            MISALIGNED = misaligned_op;
        end
    end

    // Request, lane and timeout bookkeeping; request registers hold steady through ACCESS
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            dmem_addr_q  <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            read_data_q  <= '0;
            lane_q       <= '0;
            ld_op_q      <= LD_NONE;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_issue) begin
                        dmem_addr_q <= ALU_RESULT[ADDR_WIDTH-1:2];
                        lane_q      <= addr_lo;
                        cnt_q       <= '0;
                        if (wr_op) begin
                            dmem_write_q <= 1'b1;
                            wdata_q      <= st_lanes.data;
                            be_q         <= st_lanes.be;
                            ld_op_q      <= LD_NONE;
                        end else begin
                            dmem_read_q <= 1'b1;
                            be_q        <= 4'b0000;
                            ld_op_q     <= MEM_READ;
                        end
                    end
                end
                S_ACCESS: begin
                    cnt_q <= cnt_inc[CNT_W-1:0];
                    if (DMEM_ACK) begin
                        dmem_read_q  <= 1'b0;
                        dmem_write_q <= 1'b0;
                        if (ld_op_q != LD_NONE) read_data_q <= load_ext;
                    end else if (timeout_hit) begin
                        dmem_read_q  <= 1'b0;
                        dmem_write_q <= 1'b0;
                        bus_err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DMEM_READ      = dmem_read_q;
    assign DMEM_WRITE     = dmem_write_q;
    assign DMEM_ADDRESS   = dmem_addr_q;
    assign DMEM_WRITEDATA = wdata_q;
    assign DMEM_BYTEEN    = be_q;
    assign READ_DATA      = read_data_q;
    assign BUS_ERR        = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit with a word-array memory responder.
// Latency: checks stall length, request count and result timing per op.
// Backpressure: drives DMEM_ACK after a chosen number of ACCESS cycles, or never.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] ALU_RESULT;
    logic [31:0] OUT2;
    logic        BUSY_WAIT;
    logic [31:0] READ_DATA;
    logic        MISALIGNED;
    logic        BUS_ERR;
    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic [29:0] DMEM_ADDRESS;
    logic [31:0] DMEM_WRITEDATA;
    logic [3:0]  DMEM_BYTEEN;
    logic [31:0] DMEM_READDATA;
    logic        DMEM_ACK;

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] word;
        bit          pre;
        int          ack_at;
        bit          spur;
        bit          mis;
        int          busy;
        bit          err;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] rdata;
    } vec_t;

    logic [31:0] bmem [64];
    logic [31:0] rmem [64];
    logic [31:0] model_rd;
    int          n_vec = 0;
    int          n_err = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .ALU_RESULT     (ALU_RESULT),
        .OUT2           (OUT2),
        .BUSY_WAIT      (BUSY_WAIT),
        .READ_DATA      (READ_DATA),
        .MISALIGNED     (MISALIGNED),
        .BUS_ERR        (BUS_ERR),
        .DMEM_READ      (DMEM_READ),
        .DMEM_WRITE     (DMEM_WRITE),
        .DMEM_ADDRESS   (DMEM_ADDRESS),
        .DMEM_WRITEDATA (DMEM_WRITEDATA),
        .DMEM_BYTEEN    (DMEM_BYTEEN),
        .DMEM_READDATA  (DMEM_READDATA),
        .DMEM_ACK       (DMEM_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Access size in bytes, 0 when no op is selected; a valid store wins over a load
    function automatic int op_size(input logic [2:0] rd, input logic [2:0] wr);
        if (wr >= 3'd1 && wr <= 3'd3) return (wr == 3'd1) ? 1 : (wr == 3'd2) ? 2 : 4;
        case (rd)
            3'd1, 3'd4: return 1;
            3'd2, 3'd5: return 2;
            3'd3:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] rd, input logic [31:0] word,
                                               input logic [31:0] addr);
        longint v;
        int     sh;
        sh = int'(addr % 4) * 8;
        v  = longint'(word);
        case (rd)
            3'd1: begin v = (v >> sh) % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: begin v = (v >> sh) % 256; end
            3'd2: begin v = (v >> sh) % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: begin v = (v >> sh) % 65536; end
            default: ;
        endcase
        return v[31:0];
    endfunction

    // One op through the pipeline slot, acting as memory; returns what was observed
    task automatic run_op(input vec_t v, output int busy, output int reqs, output int errs,
                          output bit misal, output bit saw_rd, output bit saw_wr,
                          output logic [29:0] waddr, output logic [31:0] wdata,
                          output logic [3:0] be);
        bit busy_seen;
        bit fin;
        int idx;
        busy = 0; reqs = 0; errs = 0; misal = 0; saw_rd = 0; saw_wr = 0;
        waddr = '0; wdata = '0; be = '0; busy_seen = 0; fin = 0;
        @(negedge CLK);
        MEM_READ = v.rd; MEM_WRITE = v.wr; ALU_RESULT = v.addr; OUT2 = v.data;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            #1;
            if (cyc == 0) misal = MISALIGNED;
            if (BUS_ERR) errs++;
            if (BUSY_WAIT) begin busy++; busy_seen = 1; end
            DMEM_ACK = 1'b0;
            DMEM_READDATA = $urandom;
            if (DMEM_READ || DMEM_WRITE) begin
                reqs++;
                if (reqs == 1) begin
                    waddr = DMEM_ADDRESS; wdata = DMEM_WRITEDATA; be = DMEM_BYTEEN;
                end
                saw_rd |= DMEM_READ;
                saw_wr |= DMEM_WRITE;
                if (reqs == v.ack_at) begin
                    DMEM_ACK = 1'b1;
                    idx = int'(DMEM_ADDRESS[5:0]);
                    if (DMEM_READ) DMEM_READDATA = bmem[idx];
                    if (DMEM_WRITE) begin
                        for (int k = 0; k < 4; k++)
                            if (DMEM_BYTEEN[k]) bmem[idx][8*k +: 8] = DMEM_WRITEDATA[8*k +: 8];
                    end
                end
            end else if (cyc == 0 && v.spur) begin
                DMEM_ACK = 1'b1;
            end
            if ((busy_seen && !BUSY_WAIT) || (!busy_seen && cyc >= 3)) begin
                fin = 1;
                MEM_READ = 3'd0; MEM_WRITE = 3'd0;
            end else begin
                @(negedge CLK);
            end
        end
        DMEM_ACK = 1'b0;
    endtask

    task automatic apply_and_check(input string tag, input vec_t v);
        int          busy, reqs, errs;
        bit          misal, srd, swr, st;
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        if (v.pre) bmem[int'(v.addr[7:2])] = v.word;
        run_op(v, busy, reqs, errs, misal, srd, swr, waddr, wdata, be);
        st = (v.wr >= 3'd1 && v.wr <= 3'd3);
        check({tag, ".misaligned"}, 32'(misal), 32'(v.mis));
        check({tag, ".busy_cycles"}, 32'(busy), 32'(v.busy));
        check({tag, ".req_cycles"}, 32'(reqs), 32'((v.busy > 0) ? v.busy - 1 : 0));
        check({tag, ".bus_err_cycles"}, 32'(errs), 32'(v.err));
        if (v.busy > 0) begin
            check({tag, ".word_addr"}, 32'(waddr), 32'(v.addr[31:2]));
            check({tag, ".is_write"}, 32'(swr), 32'(st));
            check({tag, ".is_read"}, 32'(srd), 32'(!st));
            check({tag, ".byteen"}, 32'(be), 32'(v.be));
            if (st) check({tag, ".wdata"}, wdata, v.wd);
        end
        check({tag, ".read_data"}, READ_DATA, v.rdata);
    endtask

    vec_t tbl [20];

    initial begin
        // rd, wr, addr, data, word, pre, ack_at, spur | mis, busy, err, wd, be, rdata
        tbl[0]  = '{3'd3, 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 2, 0, 0, 3, 0, 32'h0, 4'h0, 32'hDEADBEEF};
        tbl[1]  = '{3'd1, 3'd0, 32'h13, 32'h0, 32'h80FF0000, 1, 1, 0, 0, 2, 0, 32'h0, 4'h0, 32'hFFFFFF80};
        tbl[2]  = '{3'd4, 3'd0, 32'h13, 32'h0, 32'h80FF0000, 1, 1, 0, 0, 2, 0, 32'h0, 4'h0, 32'h00000080};
        tbl[3]  = '{3'd5, 3'd0, 32'h12, 32'h0, 32'h80FF0000, 1, 1, 0, 0, 2, 0, 32'h0, 4'h0, 32'h000080FF};
        tbl[4]  = '{3'd2, 3'd0, 32'h12, 32'h0, 32'h80FF0000, 1, 3, 0, 0, 4, 0, 32'h0, 4'h0, 32'hFFFF80FF};
        tbl[5]  = '{3'd0, 3'd1, 32'h21, 32'h123456AB, 32'h0, 1, 1, 0, 0, 2, 0, 32'hABABABAB, 4'h2, 32'hFFFF80FF};
        tbl[6]  = '{3'd0, 3'd2, 32'h22, 32'h123456AB, 32'h0, 1, 2, 0, 0, 3, 0, 32'h56AB56AB, 4'hC, 32'hFFFF80FF};
        tbl[7]  = '{3'd0, 3'd3, 32'h24, 32'h123456AB, 32'h0, 1, 1, 0, 0, 2, 0, 32'h123456AB, 4'hF, 32'hFFFF80FF};
        tbl[8]  = '{3'd3, 3'd0, 32'h02, 32'h0, 32'h0, 1, 1, 0, 1, 0, 0, 32'h0, 4'h0, 32'hFFFF80FF};
        tbl[9]  = '{3'd2, 3'd0, 32'h11, 32'h0, 32'h0, 1, 1, 0, 1, 0, 0, 32'h0, 4'h0, 32'hFFFF80FF};
        tbl[10] = '{3'd0, 3'd2, 32'h23, 32'h0, 32'h0, 1, 1, 0, 1, 0, 0, 32'h0, 4'h0, 32'hFFFF80FF};
        tbl[11] = '{3'd0, 3'd3, 32'h26, 32'h0, 32'h0, 1, 1, 0, 1, 0, 0, 32'h0, 4'h0, 32'hFFFF80FF};
        tbl[12] = '{3'd3, 3'd0, 32'h30, 32'h0, 32'h0BADF00D, 1, 0, 0, 0, 5, 1, 32'h0, 4'h0, 32'hFFFF80FF};
        tbl[13] = '{3'd3, 3'd0, 32'h30, 32'h0, 32'h0BADF00D, 1, 4, 0, 0, 5, 0, 32'h0, 4'h0, 32'h0BADF00D};
        tbl[14] = '{3'd3, 3'd1, 32'h41, 32'hCAFE0077, 32'h0, 1, 1, 0, 0, 2, 0, 32'h77777777, 4'h2, 32'h0BADF00D};
        tbl[15] = '{3'd6, 3'd0, 32'h40, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0BADF00D};
        tbl[16] = '{3'd0, 3'd5, 32'h40, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0BADF00D};
        tbl[17] = '{3'd1, 3'd0, 32'h10, 32'h0, 32'h0000007F, 1, 3, 1, 0, 4, 0, 32'h0, 4'h0, 32'h0000007F};
        tbl[18] = '{3'd4, 3'd0, 32'h1C, 32'h0, 32'h12345678, 1, 1, 0, 0, 2, 0, 32'h0, 4'h0, 32'h00000078};
        tbl[19] = '{3'd2, 3'd0, 32'h0E, 32'h0, 32'h80012345, 1, 1, 0, 0, 2, 0, 32'h0, 4'h0, 32'hFFFF8001};

        for (int i = 0; i < 64; i++) begin bmem[i] = '0; rmem[i] = '0; end
        RESET = 1'b1; MEM_READ = 3'd3; MEM_WRITE = 3'd0; ALU_RESULT = 32'h0; OUT2 = 32'h0;
        DMEM_READDATA = 32'h0; DMEM_ACK = 1'b0;

        // Reset holds everything low even with an aligned load presented
        @(negedge CLK); @(negedge CLK); #1;
        check("reset.busy_wait", 32'(BUSY_WAIT), 32'd0);
        check("reset.dmem_read", 32'(DMEM_READ), 32'd0);
        check("reset.read_data", READ_DATA, 32'd0);
        MEM_READ = 3'd0;
        @(negedge CLK); RESET = 1'b0;
        @(negedge CLK); #1;
        check("idle.busy_wait", 32'(BUSY_WAIT), 32'd0);
        check("idle.bus_err", 32'(BUS_ERR), 32'd0);
        check("idle.dmem_write", 32'(DMEM_WRITE), 32'd0);
        check("idle.byteen", 32'(DMEM_BYTEEN), 32'd0);

        for (int i = 0; i < 20; i++) apply_and_check($sformatf("tbl%0d", i), tbl[i]);

        // Reset in the middle of an open read
        @(negedge CLK);
        MEM_READ = 3'd3; ALU_RESULT = 32'h40;
        @(negedge CLK); #1;
        check("rstmid.req_open", 32'(DMEM_READ), 32'd1);
        RESET = 1'b1; #1;
        check("rstmid.dmem_read", 32'(DMEM_READ), 32'd0);
        check("rstmid.busy_wait", 32'(BUSY_WAIT), 32'd0);
        check("rstmid.read_data", READ_DATA, 32'd0);
        MEM_READ = 3'd0;
        @(negedge CLK); RESET = 1'b0;
        begin
            vec_t v;
            v = '{3'd3, 3'd0, 32'h44, 32'h0, 32'h5A5AA5A5, 1, 1, 0, 0, 2, 0, 32'h0, 4'h0, 32'h5A5AA5A5};
            apply_and_check("post_reset_lw", v);
        end
        model_rd = 32'h5A5AA5A5;

        // Randomized ops against the reference model
        for (int i = 0; i < 64; i++) begin bmem[i] = $urandom; rmem[i] = bmem[i]; end
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            int   sz, off, idx;
            bit   st, iss, tmo;
            v.rd     = 3'($urandom_range(0, 7));
            v.wr     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            v.addr   = $urandom;
            v.data   = $urandom;
            v.word   = '0;
            v.pre    = 0;
            v.ack_at = int'($urandom_range(0, 5));
            v.spur   = ($urandom_range(0, 3) == 0);
            st  = (v.wr >= 3'd1 && v.wr <= 3'd3);
            sz  = op_size(v.rd, v.wr);
            off = int'(v.addr % 4);
            idx = int'((v.addr / 4) % 64);
            iss = (sz != 0) && (v.addr % sz == 0);
            tmo = iss && (v.ack_at == 0 || v.ack_at > TO);
            v.mis  = (sz != 0) && !iss;
            v.busy = iss ? 1 + (tmo ? TO : v.ack_at) : 0;
            v.err  = tmo;
            v.wd   = (sz == 1) ? v.data[7:0] * 32'h01010101 :
                     (sz == 2) ? v.data[15:0] * 32'h00010001 : v.data;
            v.be   = st ? 4'(((1 << sz) - 1) << off) : 4'h0;
            if (iss && !tmo) begin
                if (st) begin
                    for (int k = 0; k < sz; k++) rmem[idx][8*(off + k) +: 8] = v.data[8*k +: 8];
                end else begin
                    model_rd = load_value(v.rd, rmem[idx], v.addr);
                end
            end
            v.rdata = model_rd;
            apply_and_check($sformatf("rnd%0d", i), v);
        end
        for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), bmem[i], rmem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
